// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU mapping-RAM sequencer: sequencer states,
// slot phases, chip-select codes and the default map entry for an address.
package mmu_pkg;

   localparam int MMU_ENTRIES = 256;

   localparam logic [1:0] CS_ROM0 = 2'b00;
   localparam logic [1:0] CS_ROM1 = 2'b01;
   localparam logic [1:0] CS_RAM  = 2'b10;
   localparam logic [1:0] CS_EXT  = 2'b11;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_IDLE   = 2'd2,
      ST_HOST   = 2'd3
   } seq_state_t;

   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_A    = 2'd1,
      PH_H    = 2'd2
   } slot_phase_t;

   // Slot 7 of every task maps ROM0 page 7; the other slots map RAM pages.
   function automatic logic [7:0] default_entry(input logic [7:0] addr,
                                                input logic [1:0] def_cs,
                                                input logic [7:0] top_entry);
      if (addr[2:0] == 3'd7)
         return top_entry;
      return {def_cs, 3'b000, addr[2:0]};
   endfunction

endpackage

// File: rtl/mmu_slot_timer.sv
// Free-slot detector and A/H access sequencer for the MMU RAM port.
// A request offered while a slot is detected is launched into the next
// CLKX4 cycle ({QX,EX}=00, A) and held for one more cycle (10, H).
import mmu_pkg::*;

module mmu_slot_timer (
   input  logic       CLKX4,
   input  logic       nRESET,
   input  logic       QX,
   input  logic       EX,
   input  logic       MRDY,
   input  logic       start_req,
   input  logic       start_we,
   input  logic [7:0] start_addr,
   input  logic [7:0] start_wdata,
   input  logic [7:0] MMU_DATA_IN,
   output logic       slot_next,
   output logic       acc_done,
   output logic [7:0] rd_data,
   output logic       seq_own,
   output logic [7:0] seq_addr,
   output logic [7:0] seq_wdata,
   output logic       seq_data_oe,
   output logic       seq_nWR,
   output logic       seq_nRD
);

   slot_phase_t phase;
   logic        we_q;

   // A stretched E cycle (MRDY low) never offers a slot.
   assign slot_next = ({QX, EX} == 2'b01) & MRDY;
   assign acc_done  = (phase == PH_H);

   // Slot phase sequencing with registered strobes and bus ownership.
   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         phase       <= PH_IDLE;
         we_q        <= 1'b0;
         rd_data     <= 8'h00;
         seq_own     <= 1'b0;
         seq_addr    <= 8'h00;
         seq_wdata   <= 8'h00;
         seq_data_oe <= 1'b0;
         seq_nWR     <= 1'b1;
         seq_nRD     <= 1'b1;
      end else begin
         case (phase)
            PH_IDLE: begin
               if (slot_next && start_req) begin
                  phase       <= PH_A;
                  we_q        <= start_we;
                  seq_own     <= 1'b1;
                  seq_addr    <= start_addr;
                  seq_wdata   <= start_wdata;
                  seq_data_oe <= start_we;
                  seq_nWR     <= ~start_we;
                  seq_nRD     <= start_we;
               end
            end
            PH_A: begin
               phase   <= PH_H;
               seq_nWR <= 1'b1;
               seq_nRD <= 1'b1;
               if (!we_q)
                  rd_data <= MMU_DATA_IN;
            end
            PH_H: begin
               phase       <= PH_IDLE;
               seq_own     <= 1'b0;
               seq_data_oe <= 1'b0;
            end
            default: begin
               phase   <= PH_IDLE;
               seq_own <= 1'b0;
               seq_nWR <= 1'b1;
               seq_nRD <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/mmu_ram_sequencer.sv
// MMU mapping-RAM sequencer: fills every entry with its default map after
// reset while the CPU is held off, then serves single host accesses.
// Optional build macro MMU_INIT_VERIFY_EN adds a read-back verify pass and
// the sticky init_err output.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_FILL   | write default entry fill_cnt in each free slot
// ST_VERIFY | read back entry fill_cnt and compare with its default
// ST_IDLE   | wait for a free slot with hst_req high
// ST_HOST   | latched host access in flight; ack after its hold cycle
import mmu_pkg::*;

module mmu_ram_sequencer #(
   parameter logic [1:0] DEF_CS      = CS_RAM,
   parameter logic [7:0] TOP_ENTRY   = {CS_ROM0, 6'h07},
   parameter int         NUM_ENTRIES = MMU_ENTRIES
) (
   input  logic       CLKX4,
   input  logic       nRESET,
   input  logic       QX,
   input  logic       EX,
   input  logic       MRDY,
   input  logic [7:0] MMU_DATA_IN,
   output logic       seq_own,
   output logic [7:0] seq_addr,
   output logic [7:0] seq_wdata,
   output logic       seq_data_oe,
   output logic       seq_nWR,
   output logic       seq_nRD,
   output logic       cpu_run,
   output logic       init_done,
`ifdef MMU_INIT_VERIFY_EN
   output logic       init_err,
`endif
   input  logic       hst_req,
   input  logic       hst_we,
   input  logic [7:0] hst_addr,
   input  logic [7:0] hst_wdata,
   output logic       hst_ack,
   output logic [7:0] hst_rdata
);

   localparam logic [7:0] LAST = 8'(NUM_ENTRIES - 1);

   seq_state_t state;
   logic [7:0] fill_cnt;
   logic       lat_we;

   logic       slot_next;
   logic       acc_done;
   logic [7:0] rd_data;
   logic       start_req;
   logic       start_we;
   logic [7:0] start_addr;
   logic [7:0] start_wdata;

   // Offer the next access to the slot timer: fill and verify always have
   // one pending, the host only while idle and requesting.
   always_comb begin
      start_req   = 1'b0;
      start_we    = 1'b0;
      start_addr  = fill_cnt;
      start_wdata = default_entry(fill_cnt, DEF_CS, TOP_ENTRY);
      case (state)
         ST_FILL: begin
            start_req = 1'b1;
            start_we  = 1'b1;
         end
         ST_VERIFY: begin
            start_req = 1'b1;
         end
         ST_IDLE: begin
            start_req   = hst_req;
            start_we    = hst_we;
            start_addr  = hst_addr;
            start_wdata = hst_wdata;
         end
         default: ;
      endcase
   end

   mmu_slot_timer u_slot (
      .CLKX4       (CLKX4),
      .nRESET      (nRESET),
      .QX          (QX),
      .EX          (EX),
      .MRDY        (MRDY),
      .start_req   (start_req),
      .start_we    (start_we),
      .start_addr  (start_addr),
      .start_wdata (start_wdata),
      .MMU_DATA_IN (MMU_DATA_IN),
      .slot_next   (slot_next),
      .acc_done    (acc_done),
      .rd_data     (rd_data),
      .seq_own     (seq_own),
      .seq_addr    (seq_addr),
      .seq_wdata   (seq_wdata),
      .seq_data_oe (seq_data_oe),
      .seq_nWR     (seq_nWR),
      .seq_nRD     (seq_nRD)
   );

   // Sequencer state, fill counter and host handshake.
   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         state     <= ST_FILL;
         fill_cnt  <= 8'h00;
         lat_we    <= 1'b0;
         cpu_run   <= 1'b0;
         init_done <= 1'b0;
         hst_ack   <= 1'b0;
         hst_rdata <= 8'h00;
`ifdef MMU_INIT_VERIFY_EN
         init_err  <= 1'b0;
`endif
      end else begin
         hst_ack <= 1'b0;
         case (state)
            ST_FILL: begin
               if (acc_done) begin
                  if (fill_cnt == LAST) begin
                     fill_cnt <= 8'h00;
`ifdef MMU_INIT_VERIFY_EN
                     state <= ST_VERIFY;
`else
                     state     <= ST_IDLE;
                     init_done <= 1'b1;
                     cpu_run   <= 1'b1;
`endif
                  end else begin
                     fill_cnt <= fill_cnt + 8'd1;
                  end
               end
            end
`ifdef MMU_INIT_VERIFY_EN
            ST_VERIFY: begin
               if (acc_done) begin
                  if (rd_data != default_entry(fill_cnt, DEF_CS, TOP_ENTRY))
                     init_err <= 1'b1;
                  if (fill_cnt == LAST) begin
                     fill_cnt  <= 8'h00;
                     state     <= ST_IDLE;
                     init_done <= 1'b1;
                     cpu_run   <= 1'b1;
                  end else begin
                     fill_cnt <= fill_cnt + 8'd1;
                  end
               end
            end
`endif
            ST_IDLE: begin
               if (slot_next && hst_req) begin
                  state  <= ST_HOST;
                  lat_we <= hst_we;
               end
            end
            ST_HOST: begin
               if (acc_done) begin
                  hst_ack <= 1'b1;
                  if (!lat_we)
                     hst_rdata <= rd_data;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_mmu_ram_sequencer.sv
// Scoreboard bench for mmu_ram_sequencer: a behavioural RAM sits on the
// sequencer port, expected strobes and acks are queued by the stimulus and
// popped by an independent monitor.
module tb_mmu_ram_sequencer;

`ifdef MMU_INIT_VERIFY_EN
   localparam int FILL_SLOTS = 512;
`else
   localparam int FILL_SLOTS = 256;
`endif

   logic       CLKX4 = 1'b0;
   logic       nRESET;
   logic       QX, EX, MRDY;
   logic [7:0] MMU_DATA_IN;
   logic       seq_own, seq_data_oe, seq_nWR, seq_nRD;
   logic [7:0] seq_addr, seq_wdata;
   logic       cpu_run, init_done;
`ifdef MMU_INIT_VERIFY_EN
   logic       init_err;
`endif
   logic       hst_req, hst_we, hst_ack;
   logic [7:0] hst_addr, hst_wdata, hst_rdata;

   mmu_ram_sequencer dut (
      .CLKX4       (CLKX4),
      .nRESET      (nRESET),
      .QX          (QX),
      .EX          (EX),
      .MRDY        (MRDY),
      .MMU_DATA_IN (MMU_DATA_IN),
      .seq_own     (seq_own),
      .seq_addr    (seq_addr),
      .seq_wdata   (seq_wdata),
      .seq_data_oe (seq_data_oe),
      .seq_nWR     (seq_nWR),
      .seq_nRD     (seq_nRD),
      .cpu_run     (cpu_run),
      .init_done   (init_done),
`ifdef MMU_INIT_VERIFY_EN
      .init_err    (init_err),
`endif
      .hst_req     (hst_req),
      .hst_we      (hst_we),
      .hst_addr    (hst_addr),
      .hst_wdata   (hst_wdata),
      .hst_ack     (hst_ack),
      .hst_rdata   (hst_rdata)
   );

   always #5 CLKX4 = ~CLKX4;

   typedef struct { bit we; logic [7:0] addr; logic [7:0] data; } strobe_t;
   typedef struct { bit rd; logic [7:0] data; } ack_t;

   strobe_t    sq[$];
   ack_t       aq[$];
   logic [7:0] model[256];
   logic [7:0] ram[256];
   logic [7:0] exp_last_rd;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         fill_slots = 0;
   int         fill_writes = 0;
   int         done_cycle = 0;
   bit         done_seen = 0;
   bit         slot_q = 0;
   bit         fault_en = 0;
   int         mrdy_mode = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] dflt(input int a);
      if (a % 8 == 7) return 8'h07;
      return 8'h80 + 8'(a % 8);
   endfunction

   // Clock generator phases 00,10,11,01 and MRDY stimulus mode.
   initial begin
      logic [1:0] ph;
      ph = 2'd0; QX = 1'b0; EX = 1'b0; MRDY = 1'b1;
      forever begin
         @(posedge CLKX4); #1;
         ph = ph + 2'd1;
         case (ph)
            2'd0: {QX, EX} = 2'b00;
            2'd1: {QX, EX} = 2'b10;
            2'd2: {QX, EX} = 2'b11;
            default: {QX, EX} = 2'b01;
         endcase
         if (mrdy_mode == 0) MRDY = 1'b1;
         else if (mrdy_mode == 1) MRDY = ($urandom_range(0, 3) != 0);
         else MRDY = 1'b0;
      end
   end

   assign MMU_DATA_IN = ram[seq_addr] ^ {7'b0, (fault_en && seq_addr == 8'h11)};

   // RAM model, cycle counter, slot tracking.
   always @(posedge CLKX4) begin
      cyc <= cyc + 1;
      slot_q <= ({QX, EX} == 2'b01) && MRDY;
      if (!nRESET) fill_slots <= 0;
      else if (!init_done && {QX, EX} == 2'b01 && MRDY) fill_slots <= fill_slots + 1;
      if (nRESET && seq_own && !seq_nWR) ram[seq_addr] <= seq_wdata;
   end

   // Monitor: every strobe and ack is popped against the scoreboard.
   always @(negedge CLKX4) begin
      strobe_t e;
      ack_t    k;
      if (!nRESET) begin
         done_seen   = 0;
         fill_writes = 0;
      end else begin
         if (!seq_nWR || !seq_nRD) begin
            check("strobe_in_free_slot", {31'b0, slot_q}, 1);
            check("strobe_phase", {30'b0, QX, EX}, 2'b00);
            check("strobe_own", {31'b0, seq_own}, 1);
            if (!seq_nWR && !init_done) fill_writes++;
            if (sq.size() == 0) begin
               check("unexpected_strobe", 1, 0);
            end else begin
               e = sq.pop_front();
               check("strobe_we", {31'b0, ~seq_nWR}, {31'b0, e.we});
               check("strobe_addr", {24'b0, seq_addr}, {24'b0, e.addr});
               check("strobe_oe", {31'b0, seq_data_oe}, {31'b0, e.we});
               if (e.we) check("strobe_wdata", {24'b0, seq_wdata}, {24'b0, e.data});
            end
         end
         if (seq_own && seq_nWR && seq_nRD)
            check("hold_phase", {30'b0, QX, EX}, 2'b10);
         if ({QX, EX} == 2'b11)
            check("own_released", {31'b0, seq_own}, 0);
         if (hst_ack) begin
            check("ack_phase", {30'b0, QX, EX}, 2'b11);
            check("ack_after_init", {31'b0, init_done}, 1);
            if (aq.size() == 0) begin
               check("unexpected_ack", 1, 0);
            end else begin
               k = aq.pop_front();
               check(k.rd ? "read_data" : "rdata_kept", {24'b0, hst_rdata}, {24'b0, k.data});
            end
         end
         if (init_done && !done_seen) begin
            done_seen  = 1;
            done_cycle = cyc;
            check("done_phase", {30'b0, QX, EX}, 2'b11);
            check("cpu_run_with_done", {31'b0, cpu_run}, 1);
            check("fill_slot_count", fill_slots, FILL_SLOTS);
            check("fill_write_count", fill_writes, 256);
            check("fill_queue_drained", sq.size() <= 1, 1);
         end
      end
   end

   task automatic reset_and_prime();
      nRESET = 1'b0;
      repeat (3) @(posedge CLKX4);
      #1;
      check("rst_seq_own", {31'b0, seq_own}, 0);
      check("rst_seq_addr", {24'b0, seq_addr}, 0);
      check("rst_seq_wdata", {24'b0, seq_wdata}, 0);
      check("rst_seq_oe", {31'b0, seq_data_oe}, 0);
      check("rst_nWR", {31'b0, seq_nWR}, 1);
      check("rst_nRD", {31'b0, seq_nRD}, 1);
      check("rst_cpu_run", {31'b0, cpu_run}, 0);
      check("rst_init_done", {31'b0, init_done}, 0);
      check("rst_hst_ack", {31'b0, hst_ack}, 0);
      check("rst_hst_rdata", {24'b0, hst_rdata}, 0);
`ifdef MMU_INIT_VERIFY_EN
      check("rst_init_err", {31'b0, init_err}, 0);
`endif
      sq.delete();
      aq.delete();
      exp_last_rd = 8'h00;
      for (int i = 0; i < 256; i++) begin
         model[i] = dflt(i);
         sq.push_back('{we: 1'b1, addr: 8'(i), data: dflt(i)});
      end
`ifdef MMU_INIT_VERIFY_EN
      for (int i = 0; i < 256; i++)
         sq.push_back('{we: 1'b0, addr: 8'(i), data: 8'h00});
`endif
   endtask

   task automatic release_reset();
      @(posedge CLKX4); #1;
      nRESET = 1'b1;
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      while (!init_done && n < 8000) begin
         @(negedge CLKX4);
         n++;
      end
      if (!init_done) check("init_timeout", 0, 1);
   endtask

   task automatic queue_host(input bit we, input logic [7:0] a, input logic [7:0] d);
      sq.push_back('{we: we, addr: a, data: d});
      if (we) begin
         model[a] = d;
      end else begin
         exp_last_rd = model[a];
      end
      aq.push_back('{rd: !we, data: exp_last_rd});
      hst_req = 1'b1; hst_we = we; hst_addr = a; hst_wdata = d;
   endtask

   task automatic wait_ack_drop(output int ack_cyc);
      int n;
      n = 0;
      ack_cyc = 0;
      do begin
         @(negedge CLKX4);
         n++;
      end while (!hst_ack && n < 8000);
      if (!hst_ack) check("ack_timeout", 0, 1);
      ack_cyc = cyc;
      @(posedge CLKX4); #1;
      hst_req = 1'b0;
   endtask

   task automatic host_op(input bit we, input logic [7:0] a, input logic [7:0] d);
      int c;
      @(posedge CLKX4); #1;
      queue_host(we, a, d);
      wait_ack_drop(c);
   endtask

   initial begin
      int ack_cyc;
      int n;
      nRESET = 1'b0;
      hst_req = 1'b0; hst_we = 1'b0; hst_addr = 8'h00; hst_wdata = 8'h00;
      for (int i = 0; i < 256; i++) ram[i] = 8'hFF;

      // Fill with MRDY=1, host write pending from before reset release.
      reset_and_prime();
      queue_host(1'b1, 8'h12, 8'h5C);
      release_reset();
      wait_ack_drop(ack_cyc);
      check("pending_host_first_slot", ack_cyc - done_cycle, 4);
`ifdef MMU_INIT_VERIFY_EN
      check("verify_clean_err", {31'b0, init_err}, 0);
`endif
      host_op(1'b0, 8'h00, 8'h00);
      host_op(1'b0, 8'h05, 8'h00);
      host_op(1'b0, 8'h07, 8'h00);
      host_op(1'b0, 8'hFF, 8'h00);
      host_op(1'b0, 8'h12, 8'h00);
      host_op(1'b1, 8'h3A, 8'hC4);
      host_op(1'b0, 8'h3A, 8'h00);

      // Random host traffic with random MRDY stalls.
      mrdy_mode = 1;
      for (int i = 0; i < 40; i++)
         host_op(1'(($urandom_range(0, 1))), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      mrdy_mode = 0;

      // Refill, then asynchronous reset during the write strobe of 0x40.
      reset_and_prime();
      release_reset();
      n = 0;
      do begin
         @(negedge CLKX4);
         n++;
      end while (!(nRESET && !seq_nWR && seq_addr == 8'h40) && n < 4000);
      check("reached_entry_40", {24'b0, seq_addr}, 8'h40);
      #2 nRESET = 1'b0;
      #1;
      check("async_nWR_high", {31'b0, seq_nWR}, 1);
      check("async_own_low", {31'b0, seq_own}, 0);
      check("async_init_done", {31'b0, init_done}, 0);

      // Restarted fill from 0x00 with a three-E-cycle MRDY stall mid-way.
      reset_and_prime();
      release_reset();
      n = 0;
      while (fill_writes < 100 && n < 4000) begin
         @(negedge CLKX4);
         n++;
      end
      check("refill_progress", fill_writes >= 100, 1);
      check("done_low_mid_refill", {31'b0, init_done}, 0);
      @(posedge CLKX4); #1;
      mrdy_mode = 2;
      repeat (12) @(posedge CLKX4);
      mrdy_mode = 0;
      wait_init();
      host_op(1'b0, 8'h40, 8'h00);
      host_op(1'b0, 8'h3A, 8'h00);
      for (int i = 0; i < 8; i++)
         host_op(1'b0, 8'($urandom_range(0, 255)), 8'h00);

`ifdef MMU_INIT_VERIFY_EN
      // Read fault at 0x11 during verify must set the sticky error.
      fault_en = 1'b1;
      reset_and_prime();
      release_reset();
      wait_init();
      repeat (4) @(negedge CLKX4);
      check("fault_init_err", {31'b0, init_err}, 1);
      check("fault_init_done", {31'b0, init_done}, 1);
      fault_en = 1'b0;
`endif

      repeat (8) @(negedge CLKX4);
      check("scoreboard_strobes_empty", sq.size(), 0);
      check("scoreboard_acks_empty", aq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmu_ram_sequencer.md
Name: mmu_ram_sequencer

Overview:
- Clocked controller for the 256x8 MMU mapping RAM (32 tasks x 8 slots).
- After reset, fills every entry with a default map while the CPU is held off, then grants a host port (debug/loader master) single-entry read/write access.
- All accesses use the one CLKX4 "free slot" per E cycle, {QX,EX}=00, when the CPU is not translating.
- Outputs feed the MMU's RAM-port mux: the MMU selects sequencer address, data and strobes whenever seq_own=1.

Parameters:
- DEF_CS, 2'b10: chip-select field (bits 7:6) for default entries, slots 0-6 (RAM).
- TOP_ENTRY, 8'h07: default data for slot 7 of every task (CS=00, ROM0 page 7).
- NUM_ENTRIES, 256: entries filled; power of two, at most 256.

Ports:
- CLKX4  in  1  system clock, 4x E
- nRESET  in  1  reset; asynchronous, active-low
- QX  in  1  clock-generator Q phase (CLKX4 domain)
- EX  in  1  clock-generator E phase (CLKX4 domain)
- MRDY  in  1  memory ready; the E-stretch state is not a free slot
- MMU_DATA_IN  in  8  MMU RAM read data
- seq_own  out  1  sequencer owns MMU RAM address and data
- seq_addr  out  8  MMU RAM address
- seq_wdata  out  8  MMU RAM write data
- seq_data_oe  out  1  drive seq_wdata onto MMU_DATA
- seq_nWR  out  1  MMU RAM write strobe, active-low
- seq_nRD  out  1  MMU RAM read strobe, active-low
- cpu_run  out  1  0 holds the CPU in reset; 1 after fill completes
- init_done  out  1  fill complete
- hst_req  in  1  host request, level, held until ack
- hst_we  in  1  1 = write, 0 = read
- hst_addr  in  8  host entry address
- hst_wdata  in  8  host write data
- hst_ack  out  1  one-cycle completion pulse
- hst_rdata  out  8  read data, valid from hst_ack until the next ack

Behaviour:
- Reset values: seq_own=0, seq_addr=0, seq_wdata=0, seq_data_oe=0, seq_nWR=1, seq_nRD=1, cpu_run=0, init_done=0, hst_ack=0, hst_rdata=0, fill counter=0, state FILL.
- Slot detect: slot_next = ({QX,EX}==2'b01) & MRDY, sampled at a CLKX4 posedge; the following cycle, {QX,EX}=00, is the access cycle (A). The cycle after that, 10, is the hold cycle (H).
- Access timing: all outputs are registered. In A: seq_own=1, strobe low (seq_nWR for writes, seq_nRD for reads). In H: seq_own=1, strobes high, address and data unchanged. After H: seq_own=0, seq_data_oe=0. Read data is captured from MMU_DATA_IN at the posedge ending A.
- States:
  - FILL: one write per slot. seq_addr = counter. Data is TOP_ENTRY when counter[2:0]=7, else {DEF_CS,3'b000,counter[2:0]}. The counter increments after H. At counter = NUM_ENTRIES-1 after H, go to the next state: VERIFY if the optional feature is enabled, else IDLE.
  - IDLE: on the first slot_next with hst_req=1, latch hst_we, hst_addr and hst_wdata, then go to HOST.
  - HOST: perform the access in A/H. hst_ack=1 for the cycle after H; hst_rdata is updated for reads only. Return to IDLE.
- init_done and cpu_run go to 1 in the same cycle the final fill or verify access completes. They stay 1 until reset.
- Host requests during FILL/VERIFY are ignored until IDLE; no ack is lost. The fill always has priority.
- hst_req must stay high until ack. Deasserting it before the latch cancels the request. After the latch, the access completes regardless of hst_req.
- Back-to-back host requests are served at most one per E cycle.
- An MRDY-stretched E cycle yields no slot; the sequencer waits with no timeout.
- nRESET mid-fill or mid-access: strobes go high immediately (asynchronous), and the fill restarts from entry 0.
- The fill takes exactly NUM_ENTRIES E cycles when MRDY=1 throughout.

Optional Feature:
- MMU_INIT_VERIFY_EN defined:
  - After FILL, a VERIFY pass reads all entries through the same slot timing and compares each with its default value.
  - Adds output init_err (1 bit, reset 0), a sticky flag set on any mismatch.
  - init_done asserts after VERIFY ends, even when init_err=1.
- MMU_INIT_VERIFY_EN undefined: no VERIFY state and no init_err port; init_done asserts directly after FILL.

Decomposition:
- Shared package mmu_pkg:
  - state encoding (FILL, VERIFY, IDLE, HOST)
  - slot-phase encoding (A, H)
  - default-entry function of the address
  - constants MMU_ENTRIES=256 and CS codes (ROM0=00, ROM1=01, RAM=10, EXT=11)
- Sub-module mmu_slot_timer: slot detect plus the A/H sequencing and strobe generation, reused by both the fill and host paths.

Test Plan:
- Reset, free-running clkgen, MRDY=1 -> exactly 256 write strobes; entry 0x00=0x80, 0x05=0x85, 0x07=0x07, 0xFF=0x07; init_done and cpu_run rise after the 256th H cycle.
- Hold MRDY=0 for 3 E cycles mid-fill -> no strobes during the stall; the fill resumes at the next address; the total write count is still 256.
- After init: host write 0x3A<=0xC4, then host read 0x3A -> hst_ack pulses one cycle after each H; hst_rdata=0xC4.
- hst_req asserted during the fill -> no ack until IDLE; the access occurs in the first slot after init_done.
- nRESET pulsed while seq_nWR=0 at entry 0x40 -> strobe rises asynchronously; the fill restarts at 0x00; init_done=0 until the refill completes.
- With MMU_INIT_VERIFY_EN, force a RAM model fault at 0x11 -> init_err=1 and init_done=1 after 512 slots; without the fault, init_err=0.
